secded_stream_decoder: RTL and testbench
========================================

SECDED_STREAM_DECODER -- requirements
Module: secded_stream_decoder

Interface
REQ-001 Parameter DATA_W, 26, data bits per codeword (4..57).
REQ-002 Parameter CNT_W, 16, error-counter width.
REQ-003 Derived constants R = smallest r with 2^r >= DATA_W+r+1, and CODE_W = DATA_W+R+1; the defaults give R=5, CODE_W=32.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  in_code holds a codeword.
REQ-007 in_ready  out  1  block accepts in_code this cycle.
REQ-008 in_code  in  CODE_W  received codeword.
REQ-009 correct_en  in  1  1 = correct single errors, 0 = detect only; sampled with each word.
REQ-010 out_valid  out  1  decoded word available.
REQ-011 out_ready  in  1  downstream accepts the output.
REQ-012 out_data  out  DATA_W  decoded data.
REQ-013 out_syndrome  out  R+1  {overall parity, Hamming syndrome}.
REQ-014 out_sec  out  1  single error detected.
REQ-015 out_ded  out  1  double or uncorrectable error detected.
REQ-016 out_corrected  out  1  a bit was flipped in out_data or the check bits.
REQ-017 cnt_clear  in  1  synchronous clear of both counters.
REQ-018 sec_count  out  CNT_W  saturating count of single-error words.
REQ-019 ded_count  out  CNT_W  saturating count of double-error words.
REQ-020 ded_irq  out  1  sticky double-error flag.
REQ-021 irq_clear  in  1  clears ded_irq.

Function
REQ-022 Codeword layout: bit 0 holds overall even parity; bits 1..CODE_W-1 are Hamming positions; check bits sit at power-of-two positions; data bits fill the remaining positions ascending, data LSB first.
REQ-023 s[R-1:0] is the XOR of all position indices whose bit is 1; ov is the XOR of all CODE_W bits; out_syndrome = {ov, s}.
REQ-024 Classification:
- ov=0, s=0: clean.
- ov=1, s<=CODE_W-1: single error at position s (s=0 means bit 0).
- ov=0, s!=0: double error.
- ov=1, s>CODE_W-1: out_ded.
REQ-025 When the word is single-error and correct_en=1, position s is flipped before data extraction and out_corrected=1; otherwise out_data is extracted raw.
REQ-026 The decoder is a two-stage pipeline: stage 1 registers the codeword, s, ov and correct_en; stage 2 registers the outputs. Latency is 2 cycles from input handshake to out_valid when not stalled.
REQ-027 Stage 2 loads when stage 1 is valid and (stage 2 is empty or out_ready=1).
REQ-028 in_ready = !s1_valid || stage-2 load; it depends on no input combinationally except out_ready.
REQ-029 While out_valid=1 and out_ready=0, every out_* signal holds stable. One word per cycle is sustained when out_ready=1.
REQ-030 Counters increment only on an output handshake with the matching flag, and saturate at all-ones.
REQ-031 cnt_clear clears both counters and wins over a simultaneous increment (result 0).
REQ-032 ded_irq sets on an output handshake with out_ded=1; irq_clear clears it; a set wins over a simultaneous clear.

Reset
REQ-033 rst clears the stage valids, out_valid, all flags, the counters and ded_irq to 0 immediately; in-flight words are discarded.
REQ-034 in_ready is 1 in the first cycle after rst deasserts.
REQ-035 Datapath registers need no reset.

Structure
REQ-036 Package secded_pkg holds: function calc_r(DATA_W); position-to-data-index mapping functions; the enum of error classes.
REQ-037 One sub-module, secded_syndrome (combinational s/ov generator, parametrised by DATA_W), is instantiated in stage 1.

Verification
REQ-038 Defaults, in_code 0xFFFFFFFF, correct_en=1 -> out_data 0x3FFFFFF, syndrome 0x00, sec=ded=0, 2 cycles latency.
REQ-039 in_code 0xFFFFFF7F (bit 7 flipped) -> out_data 0x3FFFFFF, syndrome 0x27, sec=1, corrected=1, sec_count=1; in_code 0xFFFFFFFE -> syndrome 0x20, data 0x3FFFFFF, sec=1.
REQ-040 in_code 0x00000028 -> ded=1, syndrome 0x06, out_data 0x0000003 uncorrected, ded_irq=1, ded_count=1; irq_clear together with a second such handshake -> ded_irq stays 1.
REQ-041 in_code 0x00000008, correct_en=0 -> sec=1, corrected=0, out_data 0x0000001, syndrome 0x23.
REQ-042 out_ready=0 with 3 words offered -> 2 accepted and in_ready=0 while outputs stay stable; out_ready=1 -> all 3 words delivered in order with none lost or duplicated.
REQ-043 CNT_W=4, 17 single-error words -> sec_count=15; cnt_clear -> 0; rst asserted mid-stream -> out_valid=0 and counters 0 at once.

Source files
------------

// File: rtl/secded_pkg.sv
// secded_pkg
// Shared definitions for the SECDED stream decoder:
//   calc_r       - number of Hamming check bits for a given data width
//   is_pow2      - true for check-bit positions (1, 2, 4, ...)
//   data_to_pos  - codeword position that carries data bit idx
//   pos_to_data  - data bit index carried by a (non power-of-two) position
//   err_class_e  - classification of a received codeword
package secded_pkg;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_SINGLE,
    ERR_DOUBLE,
    ERR_UNCORR
  } err_class_e;

  function automatic int calc_r(input int data_w);
    int r;
    r = 1;
    while ((1 << r) < data_w + r + 1) r++;
    return r;
  endfunction

  function automatic bit is_pow2(input int p);
    return (p > 0) && ((p & (p - 1)) == 0);
  endfunction

  // Data bits fill the non power-of-two positions in ascending order,
  // data LSB first. The bound of 128 covers the largest legal codeword.
  function automatic int data_to_pos(input int idx);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int p = 1; p < 128; p++) begin
      if (!is_pow2(p)) begin
        if (cnt == idx && pos == 0) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

  function automatic int pos_to_data(input int pos);
    int cnt;
    cnt = 0;
    for (int q = 1; q < 128; q++) begin
      if (q < pos && !is_pow2(q)) cnt++;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/secded_syndrome.sv
// secded_syndrome
// Combinational syndrome generator.
//   code : received codeword (bit 0 = overall parity, 1.. = Hamming positions)
//   syn  : XOR of the indices of every position holding a 1
//   ov   : XOR of all codeword bits (overall parity check)
module secded_syndrome
  import secded_pkg::*;
#(
  parameter  int DATA_W = 26,
  localparam int R      = calc_r(DATA_W),
  localparam int CODE_W = DATA_W + R + 1
) (
  input  logic [CODE_W-1:0] code,
  output logic [R-1:0]      syn,
  output logic              ov
);

  always_comb begin
    syn = '0;
    for (int p = 1; p < CODE_W; p++) begin
      if (code[p]) syn = syn ^ R'(p);
    end
  end

  assign ov = ^code;

endmodule

// File: rtl/secded_stream_decoder.sv
// secded_stream_decoder
// Two-stage valid/ready SECDED decoder with error counters and a sticky
// double-error interrupt.
//   clk, rst                 : clock (rising edge), async active-high reset
//   in_valid/in_ready/in_code: input stream, correct_en sampled per word
//   out_valid/out_ready      : output handshake
//   out_data, out_syndrome   : decoded data, {overall parity, syndrome}
//   out_sec/ded/corrected    : per-word error flags
//   cnt_clear, sec/ded_count : saturating error counters, sync clear
//   ded_irq, irq_clear       : sticky double-error flag
module secded_stream_decoder
  import secded_pkg::*;
#(
  parameter  int DATA_W = 26,
  parameter  int CNT_W  = 16,
  localparam int R      = calc_r(DATA_W),
  localparam int CODE_W = DATA_W + R + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  input  logic              correct_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [R:0]        out_syndrome,
  output logic              out_sec,
  output logic              out_ded,
  output logic              out_corrected,
  input  logic              cnt_clear,
  output logic [CNT_W-1:0]  sec_count,
  output logic [CNT_W-1:0]  ded_count,
  output logic              ded_irq,
  input  logic              irq_clear
);

  logic [R-1:0]      syn;
  logic              ov;
  logic              s1_valid;
  logic [CODE_W-1:0] s1_code;
  logic [R-1:0]      s1_syn;
  logic              s1_ov;
  logic              s1_cen;
  logic              s2_load;
  logic              in_fire;
  logic              out_fire;
  err_class_e        err_class;
  logic              fix_en;
  logic [CODE_W-1:0] fixed_code;
  logic [DATA_W-1:0] data_ext;

  secded_syndrome #(.DATA_W(DATA_W)) u_syndrome (
    .code (in_code),
    .syn  (syn),
    .ov   (ov)
  );

  assign s2_load  = s1_valid && (!out_valid || out_ready);
  assign in_ready = !s1_valid || s2_load;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      s1_code <= in_code;
      s1_syn  <= syn;
      s1_ov   <= ov;
      s1_cen  <= correct_en;
    end
  end

  // With odd overall parity the syndrome names the flipped position; a
  // syndrome beyond the last position cannot be a single error.
  always_comb begin
    err_class = ERR_NONE;
    if (s1_ov) begin
      if (int'(s1_syn) <= CODE_W - 1) err_class = ERR_SINGLE;
      else                            err_class = ERR_UNCORR;
    end else if (s1_syn != '0) begin
      err_class = ERR_DOUBLE;
    end
    fix_en     = (err_class == ERR_SINGLE) && s1_cen;
    fixed_code = s1_code;
    if (fix_en) fixed_code = s1_code ^ (CODE_W'(1) << s1_syn);
  end

  for (genvar i = 0; i < DATA_W; i++) begin : g_extract
    localparam int POS = data_to_pos(i);
    assign data_ext[i] = fixed_code[POS];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_sec       <= 1'b0;
      out_ded       <= 1'b0;
      out_corrected <= 1'b0;
    end else if (s2_load) begin
      out_valid     <= 1'b1;
      out_sec       <= (err_class == ERR_SINGLE);
      out_ded       <= (err_class == ERR_DOUBLE) || (err_class == ERR_UNCORR);
      out_corrected <= fix_en;
    end else if (out_ready) begin
      out_valid     <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (s2_load) begin
      out_data     <= data_ext;
      out_syndrome <= {s1_ov, s1_syn};
    end
  end

  // Clear wins over a simultaneous increment; counts stick at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sec_count <= '0;
      ded_count <= '0;
    end else if (cnt_clear) begin
      sec_count <= '0;
      ded_count <= '0;
    end else begin
      if (out_fire && out_sec && (sec_count != '1)) sec_count <= sec_count + CNT_W'(1);
      if (out_fire && out_ded && (ded_count != '1)) ded_count <= ded_count + CNT_W'(1);
    end
  end

  // A new double error wins over a simultaneous clear so none is missed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ded_irq <= 1'b0;
    end else if (out_fire && out_ded) begin
      ded_irq <= 1'b1;
    end else if (irq_clear) begin
      ded_irq <= 1'b0;
    end
  end

endmodule

// File: tb/tb_secded_stream_decoder.sv
// tb_secded_stream_decoder
// Self-checking bench: a default-width decoder and a CNT_W=4 copy share
// all inputs and are compared against a behavioural model and scoreboard.
module tb_secded_stream_decoder;

  localparam int CODE_W = 32;

  typedef struct {
    logic [25:0] data;
    logic [5:0]  syn;
    logic        sec;
    logic        ded;
    logic        corr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic [31:0] in_code = '0;
  logic        correct_en = 1'b0;
  logic        out_ready = 1'b1;
  logic        cnt_clear = 1'b0;
  logic        irq_clear = 1'b0;

  logic        in_ready, out_valid, out_sec, out_ded, out_corrected, ded_irq;
  logic [25:0] out_data;
  logic [5:0]  out_syndrome;
  logic [15:0] sec_count, ded_count;

  logic        in_ready_s, out_valid_s, out_sec_s, out_ded_s, out_corrected_s, ded_irq_s;
  logic [25:0] out_data_s;
  logic [5:0]  out_syndrome_s;
  logic [3:0]  sec_count_s, ded_count_s;

  secded_stream_decoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .correct_en(correct_en), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_syndrome(out_syndrome),
    .out_sec(out_sec), .out_ded(out_ded), .out_corrected(out_corrected),
    .cnt_clear(cnt_clear), .sec_count(sec_count), .ded_count(ded_count),
    .ded_irq(ded_irq), .irq_clear(irq_clear)
  );

  secded_stream_decoder #(.DATA_W(26), .CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_code(in_code), .correct_en(correct_en), .out_valid(out_valid_s),
    .out_ready(out_ready), .out_data(out_data_s), .out_syndrome(out_syndrome_s),
    .out_sec(out_sec_s), .out_ded(out_ded_s), .out_corrected(out_corrected_s),
    .cnt_clear(cnt_clear), .sec_count(sec_count_s), .ded_count(ded_count_s),
    .ded_irq(ded_irq_s), .irq_clear(irq_clear)
  );

  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];
  int   m_sec, m_ded, m_sec4, m_ded4;
  logic m_irq, m_s1, m_out;
  logic last_fire;
  int   out_count = 0;

  function automatic logic [31:0] encode(input logic [25:0] d);
    logic [31:0] w;
    int k;
    int s;
    w = '0;
    k = 0;
    for (int p = 1; p < CODE_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        w[p] = d[k];
        k++;
      end
    end
    s = 0;
    for (int p = 1; p < CODE_W; p++) if (w[p]) s = s ^ p;
    for (int j = 0; j < 5; j++) w[1 << j] = s[j];
    w[0] = ^w[31:1];
    return w;
  endfunction

  function automatic exp_t model(input logic [31:0] c, input logic cen);
    exp_t e;
    int s;
    int k;
    logic ov;
    logic [31:0] f;
    s = 0;
    for (int p = 1; p < CODE_W; p++) if (c[p]) s = s ^ p;
    ov = ^c;
    e.syn  = {ov, 5'(s)};
    e.sec  = ov && (s <= CODE_W - 1);
    e.ded  = (!ov && s != 0) || (ov && s > CODE_W - 1);
    e.corr = e.sec && cen;
    f = c;
    if (e.corr) f[s] = ~f[s];
    e.data = '0;
    k = 0;
    for (int p = 1; p < CODE_W; p++) begin
      if ((p & (p - 1)) != 0) begin
        e.data[k] = f[p];
        k++;
      end
    end
    return e;
  endfunction

  function automatic logic [31:0] random_word(input int n_err);
    logic [31:0] w;
    int p1;
    int p2;
    w  = encode(26'($urandom));
    p1 = int'($urandom % 32);
    p2 = (p1 + 1 + int'($urandom % 31)) % 32;
    if (n_err >= 1) w[p1] = ~w[p1];
    if (n_err >= 2) w[p2] = ~w[p2];
    return w;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    m_sec = 0; m_ded = 0; m_sec4 = 0; m_ded4 = 0;
    m_irq = 1'b0; m_s1 = 1'b0; m_out = 1'b0;
  endtask

  // One clock: check everything at the falling edge, advance the model,
  // then return 1 time unit after the rising edge.
  task automatic cycle();
    logic exp_ready, load, hs, fire;
    exp_t e;
    @(negedge clk);
    last_fire = 1'b0;
    if (!rst) begin
      load      = m_s1 && (!m_out || out_ready);
      exp_ready = !m_s1 || load;
      checkOutput("in_ready", 64'(in_ready), 64'(exp_ready));
      checkOutput("in_ready_small", 64'(in_ready_s), 64'(exp_ready));
      checkOutput("out_valid", 64'(out_valid), 64'(m_out));
      checkOutput("out_valid_small", 64'(out_valid_s), 64'(m_out));
      checkOutput("sec_count", 64'(sec_count), 64'(m_sec));
      checkOutput("ded_count", 64'(ded_count), 64'(m_ded));
      checkOutput("sec_count_small", 64'(sec_count_s), 64'(m_sec4));
      checkOutput("ded_count_small", 64'(ded_count_s), 64'(m_ded4));
      checkOutput("ded_irq", 64'(ded_irq), 64'(m_irq));
      checkOutput("ded_irq_small", 64'(ded_irq_s), 64'(m_irq));
      e = '{default: '0};
      if (m_out) begin
        checkOutput("scoreboard_nonempty", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
          e = exp_q[0];
          checkOutput("out_data", 64'(out_data), 64'(e.data));
          checkOutput("out_syndrome", 64'(out_syndrome), 64'(e.syn));
          checkOutput("out_sec", 64'(out_sec), 64'(e.sec));
          checkOutput("out_ded", 64'(out_ded), 64'(e.ded));
          checkOutput("out_corrected", 64'(out_corrected), 64'(e.corr));
          checkOutput("out_data_small", 64'(out_data_s), 64'(e.data));
          checkOutput("out_flags_small", 64'({out_syndrome_s, out_sec_s, out_ded_s, out_corrected_s}),
                      64'({e.syn, e.sec, e.ded, e.corr}));
        end
      end
      hs = m_out && out_ready;
      if (hs && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        out_count++;
      end
      if (cnt_clear) begin
        m_sec = 0; m_ded = 0; m_sec4 = 0; m_ded4 = 0;
      end else begin
        if (hs && e.sec) begin
          if (m_sec < 65535) m_sec++;
          if (m_sec4 < 15) m_sec4++;
        end
        if (hs && e.ded) begin
          if (m_ded < 65535) m_ded++;
          if (m_ded4 < 15) m_ded4++;
        end
      end
      if (hs && e.ded) m_irq = 1'b1;
      else if (irq_clear) m_irq = 1'b0;
      fire = in_valid && exp_ready;
      if (fire) begin
        exp_q.push_back(model(in_code, correct_en));
        last_fire = 1'b1;
      end
      m_out = load ? 1'b1 : (out_ready ? 1'b0 : m_out);
      m_s1  = fire ? 1'b1 : (load ? 1'b0 : m_s1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] code, input logic cen);
    logic got;
    got = 1'b0;
    in_valid   = 1'b1;
    in_code    = code;
    correct_en = cen;
    for (int i = 0; i < 50 && !got; i++) begin
      cycle();
      got = last_fire;
    end
    in_valid = 1'b0;
    checkOutput("accept_timeout", 64'(got), 64'(1));
  endtask

  task automatic expect_word(input logic [25:0] d, input logic [5:0] syn,
                             input logic sec, input logic ded, input logic corr);
    checkOutput("latency_1", 64'(out_valid), 64'(0));
    cycle();
    checkOutput("latency_2", 64'(out_valid), 64'(1));
    checkOutput("dir_data", 64'(out_data), 64'(d));
    checkOutput("dir_syndrome", 64'(out_syndrome), 64'(syn));
    checkOutput("dir_flags", 64'({out_sec, out_ded, out_corrected}), 64'({sec, ded, corr}));
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (exp_q.size() > 0 || m_out || m_s1); i++) cycle();
    checkOutput("drain_empty", 64'(exp_q.size()), 64'(0));
  endtask

  task automatic doReset();
    rst = 1'b1;
    #1;
    clear_model();
    checkOutput("rst_out_valid", 64'(out_valid), 64'(0));
    checkOutput("rst_counters", 64'({sec_count, ded_count}), 64'(0));
    checkOutput("rst_counters_small", 64'({sec_count_s, ded_count_s}), 64'(0));
    checkOutput("rst_irq", 64'({ded_irq, ded_irq_s}), 64'(0));
    checkOutput("rst_flags", 64'({out_sec, out_ded, out_corrected}), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("in_ready_after_rst", 64'(in_ready), 64'(1));
  endtask

  initial begin
    int accepted;
    int base;
    int sent;
    logic got;
    clear_model();
    last_fire = 1'b0;
    doReset();

    // Clean all-ones word, single errors, double error and detect-only mode
    applyStimulus(32'hFFFF_FFFF, 1'b1);
    expect_word(26'h3FF_FFFF, 6'h00, 1'b0, 1'b0, 1'b0);
    cycle();
    applyStimulus(32'hFFFF_FF7F, 1'b1);
    expect_word(26'h3FF_FFFF, 6'h27, 1'b1, 1'b0, 1'b1);
    cycle();
    checkOutput("sec_count_1", 64'(sec_count), 64'(1));
    applyStimulus(32'hFFFF_FFFE, 1'b1);
    expect_word(26'h3FF_FFFF, 6'h20, 1'b1, 1'b0, 1'b1);
    cycle();
    applyStimulus(32'h0000_0028, 1'b1);
    expect_word(26'h000_0003, 6'h06, 1'b0, 1'b1, 1'b0);
    cycle();
    checkOutput("ded_irq_set", 64'(ded_irq), 64'(1));
    checkOutput("ded_count_1", 64'(ded_count), 64'(1));
    applyStimulus(32'h0000_0028, 1'b1);
    expect_word(26'h000_0003, 6'h06, 1'b0, 1'b1, 1'b0);
    irq_clear = 1'b1;
    cycle();
    irq_clear = 1'b0;
    checkOutput("irq_set_wins", 64'(ded_irq), 64'(1));
    checkOutput("ded_count_2", 64'(ded_count), 64'(2));
    irq_clear = 1'b1;
    cycle();
    irq_clear = 1'b0;
    checkOutput("irq_cleared", 64'(ded_irq), 64'(0));
    applyStimulus(32'h0000_0008, 1'b0);
    expect_word(26'h000_0001, 6'h23, 1'b1, 1'b0, 1'b0);
    cycle();
    checkOutput("sec_count_3", 64'(sec_count), 64'(3));

    // Back-pressure: three words offered while the output is stalled
    out_ready = 1'b0;
    accepted  = 0;
    base      = out_count;
    for (int i = 0; i < 3; i++) begin
      in_code    = random_word(i);
      correct_en = 1'b1;
      in_valid   = 1'b1;
      cycle();
      if (last_fire) accepted++;
    end
    repeat (3) begin
      cycle();
      if (last_fire) accepted++;
      checkOutput("stall_in_ready", 64'(in_ready), 64'(0));
    end
    checkOutput("stall_accepted", 64'(accepted), 64'(2));
    out_ready = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      cycle();
      got = last_fire;
    end
    in_valid = 1'b0;
    checkOutput("stall_third_accepted", 64'(got), 64'(1));
    drain();
    checkOutput("stall_delivered", 64'(out_count - base), 64'(3));

    // Saturation of the 4-bit counters
    cnt_clear = 1'b1;
    cycle();
    cnt_clear = 1'b0;
    checkOutput("cnt_clear_0", 64'({sec_count, sec_count_s, ded_count, ded_count_s}), 64'(0));
    sent = 0;
    in_valid = 1'b1;
    in_code = random_word(1);
    correct_en = 1'($urandom);
    for (int i = 0; i < 200 && sent < 17; i++) begin
      cycle();
      if (last_fire) begin
        sent++;
        in_code = random_word(1);
        correct_en = 1'($urandom);
      end
    end
    in_valid = 1'b0;
    drain();
    checkOutput("sec_count_17", 64'(sec_count), 64'(17));
    checkOutput("sec_count_small_sat", 64'(sec_count_s), 64'(15));
    cnt_clear = 1'b1;
    cycle();
    cnt_clear = 1'b0;
    checkOutput("cnt_clear_after_sat", 64'({sec_count, sec_count_s}), 64'(0));

    // Randomised traffic with back-pressure and occasional clears
    for (int i = 0; i < 400; i++) begin
      in_valid   = ($urandom % 4) != 0;
      out_ready  = ($urandom % 4) != 0;
      cnt_clear  = ($urandom % 60) == 0;
      irq_clear  = ($urandom % 20) == 0;
      correct_en = 1'($urandom);
      in_code    = random_word(int'($urandom % 3));
      cycle();
    end
    in_valid = 1'b0; cnt_clear = 1'b0; irq_clear = 1'b0; out_ready = 1'b1;
    drain();

    // Reset while the pipeline is full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_code = random_word(int'($urandom % 3));
      cycle();
    end
    doReset();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    applyStimulus(32'hFFFF_FFFF, 1'b1);
    expect_word(26'h3FF_FFFF, 6'h00, 1'b0, 1'b0, 1'b0);
    cycle();
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
